// File: rtl/ps2_pkg.sv
// Shared scancodes, command encodings, FSM state types and the key lookup for the PS/2 command path.
// Pure definitions; no logic, latency or flow control of its own.
package ps2_pkg;

    localparam logic [7:0] KC_W   = 8'h75;
    localparam logic [7:0] KC_A   = 8'h6B;
    localparam logic [7:0] KC_S   = 8'h72;
    localparam logic [7:0] KC_D   = 8'h74;
    localparam logic [7:0] KC_RST = 8'h29;
    localparam logic [7:0] KC_LW  = 8'h1D;
    localparam logic [7:0] KC_LA  = 8'h1C;
    localparam logic [7:0] KC_LS  = 8'h1B;
    localparam logic [7:0] KC_LD  = 8'h23;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    localparam logic [2:0] CMD_D   = 3'd0;
    localparam logic [2:0] CMD_S   = 3'd1;
    localparam logic [2:0] CMD_A   = 3'd2;
    localparam logic [2:0] CMD_W   = 3'd3;
    localparam logic [2:0] CMD_RST = 3'd4;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DEC_NORM, DEC_EXT, DEC_BRK} dec_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] code;
    } key_t;

    // Arrow keys and letter keys share a command; E0-prefixed arrows reuse the same table.
    function automatic key_t key_map(input logic [7:0] b);
        key_t k;
        k.hit  = 1'b1;
        k.code = CMD_D;
        case (b)
            KC_D, KC_LD: k.code = CMD_D;
            KC_S, KC_LS: k.code = CMD_S;
            KC_A, KC_LA: k.code = CMD_A;
            KC_W, KC_LW: k.code = CMD_W;
            KC_RST:      k.code = CMD_RST;
            default:     k.hit  = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_cmd_ctrl_if.sv
// Command stream from the keyboard decoder to the game logic.
// Valid/ready: the head is held while cmd_valid=1 and cmd_ready=0.
interface ps2_cmd_ctrl_if;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;

    modport master (output cmd, output cmd_valid, input cmd_ready);
    modport slave  (input cmd, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: 2-FF sync, start/8 data/odd parity/stop framing, mid-frame timeout abort.
// byte_valid one cycle after the registered stop-bit fall; no backpressure (keyboard cannot be stalled).
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          scl_s1, scl_s2, scl_prev, sda_s1, sda_s2;
    logic          fall, timeout;
    rx_state_t     state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt, byte_nxt;
    logic          par, par_nxt, vld_nxt, err_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;

    assign fall    = scl_prev & ~scl_s2;
    assign timeout = (state != RX_IDLE) && (to_cnt == TW'(TIMEOUT_CYC));

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_nxt     = par;
        byte_nxt    = rx_byte;
        vld_nxt     = 1'b0;
        err_nxt     = 1'b0;
        to_cnt_nxt  = (fall || state == RX_IDLE) ? '0 : to_cnt + TW'(1);
        if (timeout) begin
            state_nxt  = RX_IDLE;
            err_nxt    = 1'b1;
            to_cnt_nxt = '0;
        end else if (fall) begin
            case (state)
                RX_IDLE: if (!sda_s2) begin
                    state_nxt   = RX_DATA;
                    bit_cnt_nxt = 3'd0;
                end
                RX_DATA: begin
                    shreg_nxt   = {sda_s2, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
                end
                RX_PARITY: begin
                    par_nxt   = sda_s2;
                    state_nxt = RX_STOP;
                end
                RX_STOP: begin
                    state_nxt = RX_IDLE;
                    if (sda_s2 && (^shreg ^ par)) begin
                        vld_nxt  = 1'b1;
                        byte_nxt = shreg;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: state_nxt = RX_IDLE;
            endcase
        end
    end

    // Sync stages reset high so the idle-high bus never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1     <= 1'b1;
            scl_s2     <= 1'b1;
            scl_prev   <= 1'b1;
            sda_s1     <= 1'b1;
            sda_s2     <= 1'b1;
            state      <= RX_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par        <= 1'b0;
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            to_cnt     <= '0;
        end else begin
            scl_s1     <= scl;
            scl_s2     <= scl_s1;
            scl_prev   <= scl_s2;
            sda_s1     <= sda;
            sda_s2     <= sda_s1;
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            par        <= par_nxt;
            rx_byte    <= byte_nxt;
            byte_valid <= vld_nxt;
            frame_err  <= err_nxt;
            to_cnt     <= to_cnt_nxt;
        end
    end
endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 keyboard to game command queue: make/break decode, held-key tracking, FIFO of new presses.
// cmd_valid two cycles after byte_valid; full queue without pop drops the command and pulses overflow.
module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 20000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    input  logic                  sda,
    output logic [7:0]            data_out,
    ps2_cmd_ctrl_if.master        cmd_bus,
    output logic [4:0]            keys_held,
    output logic                  frame_err,
    output logic                  overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic       byte_valid;
    dec_state_t dec_state, dec_nxt;
    logic [4:0] keys_nxt;
    logic       push, push_nxt;
    logic [2:0] push_code, push_code_nxt;
    key_t       km;
    logic       make_req;

    ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
        .rx_byte(data_out), .byte_valid(byte_valid), .frame_err(frame_err)
    );

    always_comb begin
        dec_nxt       = dec_state;
        keys_nxt      = keys_held;
        push_nxt      = 1'b0;
        push_code_nxt = push_code;
        make_req      = 1'b0;
        km            = key_map(data_out);
        if (byte_valid) begin
            case (dec_state)
                DEC_NORM: begin
                    if (data_out == PFX_EXT)      dec_nxt = DEC_EXT;
                    else if (data_out == PFX_BRK) dec_nxt = DEC_BRK;
                    else                          make_req = km.hit;
                end
                DEC_EXT: begin
                    dec_nxt = (data_out == PFX_BRK) ? DEC_BRK : DEC_NORM;
                    if (data_out != PFX_BRK) make_req = km.hit;
                end
                default: begin
                    dec_nxt = DEC_NORM;
                    if (km.hit) keys_nxt[km.code] = 1'b0;
                end
            endcase
        end
        // Typematic repeats of an already-held key are not queued again.
        if (make_req && !keys_held[km.code]) begin
            keys_nxt[km.code] = 1'b1;
            push_nxt          = 1'b1;
            push_code_nxt     = km.code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state <= DEC_NORM;
            keys_held <= 5'd0;
            push      <= 1'b0;
            push_code <= CMD_D;
        end else begin
            dec_state <= dec_nxt;
            keys_held <= keys_nxt;
            push      <= push_nxt;
            push_code <= push_code_nxt;
        end
    end

    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]   count, count_nxt;
    logic          full, pop, wr_en;
    logic [2:0]    cmd_q, head_nxt;
    logic          cmd_vld_q;

    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign pop        = cmd_vld_q & cmd_bus.cmd_ready;
    assign wr_en      = push & (~full | pop);
    assign rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_nxt = count;
        case ({wr_en, pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
        // The head register must see a command written this cycle when it lands in the head slot.
        head_nxt = (wr_en && wr_ptr == rd_ptr_nxt) ? push_code : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_q     <= 3'd0;
            cmd_vld_q <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            cmd_q     <= head_nxt;
            cmd_vld_q <= (count_nxt != '0);
            overflow  <= push & full & ~pop;
        end
    end

    assign cmd_bus.cmd       = cmd_q;
    assign cmd_bus.cmd_valid = cmd_vld_q;
endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Bench for ps2_cmd_ctrl: bit-level PS/2 frames in, expected commands queued and matched on each pop.
module tb_ps2_cmd_ctrl;
    localparam int TO   = 20000;
    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic [7:0] data_out;
    logic [4:0] keys_held;
    logic       frame_err, overflow;

    ps2_cmd_ctrl_if bus ();

    int n_chk = 0, n_fail = 0, err_cnt = 0, ovf_cnt = 0, pop_cnt = 0;
    int sb[$];
    int exp_cmd;
    int waited;
    logic [7:0] v;
    logic [7:0] key_seq [5] = '{8'h74, 8'h72, 8'h6B, 8'h75, 8'h29};

    always #5 clk = ~clk;

    ps2_cmd_ctrl #(.TIMEOUT_CYC(TO), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda),
        .data_out(data_out), .cmd_bus(bus), .keys_held(keys_held),
        .frame_err(frame_err), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_cnt++;
            if (overflow) ovf_cnt++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                exp_cmd = (sb.size() != 0) ? sb.pop_front() : 8;
                chk("cmd_pop", 32'(bus.cmd), exp_cmd);
                pop_cnt++;
            end
        end
    end

    task automatic ps2_bit(input logic b);
        sda = b;
        repeat (HALF) @(posedge clk);
        scl = 1'b0;
        repeat (HALF) @(posedge clk);
        scl = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip = 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip);
        ps2_bit(1'b1);
        sda = 1'b1;
        repeat (4 * HALF) @(posedge clk);
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation not finished within %0d cycles", 60000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_cmd", 32'(bus.cmd), 0);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        chk("rst_keys", 32'(keys_held), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single make of w
        sb.push_back(3);
        send_byte(8'h75);
        @(negedge clk);
        chk("t1_data_out", 32'(data_out), 32'h75);
        chk("t1_keys", 32'(keys_held), 32'b01000);
        chk("t1_pops", pop_cnt, 1);

        // Typematic repeat then break
        send_byte(8'h75);
        send_byte(8'hF0);
        send_byte(8'h75);
        @(negedge clk);
        chk("t2_keys", 32'(keys_held), 0);
        chk("t2_pops", pop_cnt, 1);
        chk("t2_no_err", err_cnt, 0);

        // Parity error, then a good frame
        send_byte(8'h6B, 1'b1);
        @(negedge clk);
        chk("t3_err", err_cnt, 1);
        chk("t3_data_kept", 32'(data_out), 32'h75);
        chk("t3_no_pop", pop_cnt, 1);
        sb.push_back(2);
        send_byte(8'h6B);
        @(negedge clk);
        chk("t3_data_out", 32'(data_out), 32'h6B);
        chk("t3_keys", 32'(keys_held), 32'b00100);
        chk("t3_pops", pop_cnt, 2);
        send_byte(8'hF0);
        send_byte(8'h6B);

        // Truncated frame recovered by timeout
        v = 8'h72;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(v[i]);
        sda = 1'b1;
        waited = 0;
        while (err_cnt == 1 && waited < TO + 200) begin
            @(negedge clk);
            waited++;
        end
        chk("t4_timeout_err", err_cnt, 2);
        chk("t4_not_early", 32'(waited > TO - 2 * HALF), 1);
        sb.push_back(1);
        send_byte(8'h72);
        @(negedge clk);
        chk("t4_data_out", 32'(data_out), 32'h72);
        chk("t4_pops", pop_cnt, 3);
        send_byte(8'hF0);
        send_byte(8'h72);
        chk("t4_keys", 32'(keys_held), 0);

        // Fill the queue with consumer stalled, overflow on the fifth key
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back(i);
        for (int i = 0; i < 5; i++) begin
            send_byte(key_seq[i]);
            if (i == 4) begin
                @(negedge clk);
                chk("t5_overflow", ovf_cnt, 1);
                chk("t5_keys_rst", 32'(keys_held), 32'b10000);
            end
            send_byte(8'hF0);
            send_byte(key_seq[i]);
        end
        @(negedge clk);
        chk("t5_head_valid", 32'(bus.cmd_valid), 1);
        chk("t5_head_cmd", 32'(bus.cmd), 0);
        chk("t5_keys", 32'(keys_held), 0);
        chk("t5_stalled", pop_cnt, 3);
        bus.cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_pops", pop_cnt, 7);
        chk("t5_sb_empty", sb.size(), 0);
        chk("t5_valid_low", 32'(bus.cmd_valid), 0);

        // Reset mid-frame, then normal and extended sequences
        v = 8'h29;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(v[i]);
        rst_n = 1'b0;
        sda = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_rst_data", 32'(data_out), 0);
        chk("t6_rst_valid", 32'(bus.cmd_valid), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        sb.push_back(0);
        send_byte(8'h74);
        @(negedge clk);
        chk("t6_data_out", 32'(data_out), 32'h74);
        chk("t6_pops", pop_cnt, 8);
        send_byte(8'hF0);
        send_byte(8'h74);
        sb.push_back(0);
        send_byte(8'hE0);
        send_byte(8'h74);
        @(negedge clk);
        chk("t6_ext_keys", 32'(keys_held), 32'b00001);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h74);
        @(negedge clk);
        chk("t6_ext_break", 32'(keys_held), 0);
        chk("t6_pops_final", pop_cnt, 9);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_err_total", err_cnt, 2);
        chk("t6_ovf_total", ovf_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_cmd_ctrl.md
Name: ps2_cmd_ctrl

Overview:
Receives raw PS/2 keyboard frames on scl/sda and decodes the make/break scancode stream. Maps the five game keys to 3-bit motion/reset commands and queues them for the game logic through a valid/ready FIFO. It sequences the ps2 receive datapath: bit sampling, framing, parity, timeout recovery, prefix handling and key-held tracking.

Parameters:
TIMEOUT_CYC, 20000, clk cycles without an scl falling edge mid-frame before the frame is aborted
FIFO_DEPTH, 4, command queue entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
scl  in  1  PS/2 clock from keyboard, asynchronous
sda  in  1  PS/2 data from keyboard, asynchronous
data_out  out  8  last correctly received byte
cmd  out  3  head command: d=000, s=001, a=010, w=011, rst=100
cmd_valid  out  1  queue not empty
cmd_ready  in  1  consumer accepts head when cmd_valid=1
keys_held  out  5  held state; bit index = command code (bit0 d ... bit4 rst)
frame_err  out  1  1-cycle pulse on parity, stop or timeout error
overflow  out  1  1-cycle pulse when a command is dropped on a full queue

Behaviour:
- Reset (rst_n=0, async): data_out=0, cmd=0, cmd_valid=0, keys_held=0, frame_err=0, overflow=0; all FSMs idle, queue empty. Reset mid-frame discards the partial frame.
- scl and sda each pass through a 2-FF synchronizer. A falling edge is synced scl previous=1, current=0. All sampling happens on that cycle.
- RX FSM:
  - IDLE: on fall with sda=0, go to DATA, bit_cnt=0. On fall with sda=1, stay (spurious).
  - DATA: shift sda into bit 7 of shreg and shift right (LSB first). After 8th bit, go to PARITY.
  - PARITY: latch bit, go to STOP.
  - STOP: frame is good when sda=1 and the XOR of 8 data bits and parity =1 (odd parity). Good frame: 1-cycle byte_valid, data_out updated the same edge, then IDLE. Otherwise: frame_err pulse, data_out unchanged, then IDLE.
- Timeout: counter clears on every fall and holds 0 in IDLE. When it reaches TIMEOUT_CYC outside IDLE: go to IDLE, frame_err pulse, counter cleared.
- Decoder FSM, advances on byte_valid:
  - States: NORM, EXT (after E0), BRK (after F0 or E0 F0).
  - NORM: E0 -> EXT; F0 -> BRK; key code -> make.
  - EXT: F0 -> BRK; key code -> make; other -> NORM.
  - BRK: key code -> break, then NORM; other code -> NORM silently.
  - Key codes: 23/74 -> d, 1B/72 -> s, 1C/6B -> a, 1D/75 -> w, 29 -> rst. E0-prefixed arrows map identically. Unknown codes are ignored.
  - Make: if keys_held[code]=0, set it and push the code; if already held (typematic), no push.
  - Break: clear keys_held[code]; no push.
- Queue:
  - cmd and cmd_valid come from registers and show the head the cycle after a push into an empty queue.
  - Pop when cmd_valid and cmd_ready.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push when full without a pop: command dropped, overflow pulse, keys_held still updated.
- Decode latency: byte_valid cycle +1 for push, +1 for cmd_valid.

Decomposition:
- Package ps2_pkg:
  - scancode constants (KC_W=75, KC_A=6B, KC_S=72, KC_D=74, KC_RST=29, the WASD letter codes, PFX_EXT=E0, PFX_BRK=F0)
  - 3-bit command encodings
  - RX and decoder state enums
- Sub-module ps2_rx (synchronizers, RX FSM, timeout; outputs byte, byte_valid, frame_err).
- ps2_cmd_ctrl holds the decoder, keys_held and the FIFO.

Test Plan:
1. Frame 0x75, parity 0, stop 1, cmd_ready=1 -> data_out=75, cmd=011 with cmd_valid for 1 cycle, keys_held=01000.
2. 75 again, then F0 75 -> no second command, keys_held returns to 00000, frame_err never asserted.
3. Frame 0x6B with parity 1 -> frame_err pulse, data_out unchanged, no command. Then a correct 6B -> cmd=010.
4. 4 data bits, then scl held high for TIMEOUT_CYC -> frame_err pulse, RX back to IDLE. Then full 0x72 -> cmd=001.
5. cmd_ready=0; make/break d, s, a, w, rst in turn -> 4 queued, overflow on rst while keys_held[4]=1. Raise cmd_ready -> pops 000, 001, 010, 011.
6. rst_n low after 5 bits of 0x29, then full 0x74 -> no rst command, only cmd=000. E0 74 then E0 F0 74 -> one push of 000, then held cleared.
